// File: rtl/div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient returned for a zero divisor (all ones, MIPS-style "undefined" result).
    localparam logic [DIV_WIDTH-1:0] DIV0_QUO = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_rem_sh;
    logic           w_ge;

    assign w_rem_sh = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
    // The remainder's top bit is never set between steps; folding it in keeps the compare safe.
    assign w_ge     = i_rem[WIDTH] | (w_rem_sh >= {1'b0, i_divisor});
    assign o_rem    = w_ge ? (w_rem_sh - {1'b0, i_divisor}) : w_rem_sh;
    assign o_quo    = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_seq.sv
// Iterative 32-step restoring divider with its own sequencer for MIPS DIV/DIVU in EX.
// Stalls the pipeline front while busy, pulses validE for one cycle, honours flushE.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] aE,
    input  logic [WIDTH-1:0] bE,
    input  logic             flushE,
    output logic             stallE,
    output logic             validE,
    output logic [WIDTH-1:0] loE,
    output logic [WIDTH-1:0] hiE,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       r_state;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_valid;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;
    logic             w_last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    assign w_a_mag  = (signedE && aE[WIDTH-1]) ? -aE : aE;
    assign w_b_mag  = (signedE && bE[WIDTH-1]) ? -bE : bE;
    assign w_lo_fix = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_hi_fix = r_neg_r ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_valid <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (startE && !flushE) begin
                        r_quo   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= signedE & (aE[WIDTH-1] ^ bE[WIDTH-1]);
                        r_neg_r <= signedE & aE[WIDTH-1];
                        // Zero divisor skips the iteration and reports the raw dividend.
                        if (bE == '0) begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                            r_lo    <= {WIDTH{DIV0_QUO[0]}};
                            r_hi    <= aE;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flushE) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                            r_lo    <= w_lo_fix;
                            r_hi    <= w_hi_fix;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // A flush landing on the DONE cycle must not let HI/LO be written.
    assign validE = r_valid & ~flushE;
    assign stallE = startE & ~validE & ~flushE;
    assign busy   = (r_state != IDLE);
    assign loE    = r_lo;
    assign hiE    = r_hi;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected HI/LO, latency, stall, flush and reset.
module tb_div_seq;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        startE;
    logic        signedE;
    logic [31:0] aE;
    logic [31:0] bE;
    logic        flushE;
    logic        stallE;
    logic        validE;
    logic [31:0] loE;
    logic [31:0] hiE;
    logic        busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_valid_cyc = 0;
    exp_t sb[$];

    div_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .startE  (startE),
        .signedE (signedE),
        .aE      (aE),
        .bE      (bE),
        .flushE  (flushE),
        .stallE  (stallE),
        .validE  (validE),
        .loE     (loE),
        .hiE     (hiE),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        e.lo = lo;
        e.hi = hi;
        return e;
    endfunction

    // Reference result from magnitudes using the language's own divide/modulo.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg);
        exp_t e;
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return mk(32'hFFFF_FFFF, a);
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        e.lo = (sg && (a[31] ^ b[31])) ? -q : q;
        e.hi = (sg && a[31]) ? -r : r;
        return e;
    endfunction

    // Starts a divide from IDLE, waits (bounded) for validE, scores it, then steps past DONE.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input exp_t e, input int lat, input bit hold);
        int   n;
        bit   stall_ok;
        exp_t want;
        sb.push_back(e);
        aE = a; bE = b; signedE = sg; startE = 1'b1;
        #1;
        n = 0;
        stall_ok = 1'b1;
        while (validE !== 1'b1 && n < 100) begin
            if (stallE !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_stall_while_busy"}, 64'(stall_ok), 64'd1);
        if (validE === 1'b1) begin
            last_valid_cyc = cyc;
            chk({tag, "_stall_in_done"}, 64'(stallE), 64'd0);
            if (sb.size() == 0) begin
                chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
            end else begin
                want = sb.pop_front();
                chk({tag, "_lo"}, 64'(loE), 64'(want.lo));
                chk({tag, "_hi"}, 64'(hiE), 64'(want.hi));
            end
            if (!hold) startE = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_valid_one_cycle"}, 64'(validE), 64'd0);
        end else begin
            sb.delete();
            startE = 1'b0;
        end
    endtask

    initial begin
        int first_valid;
        bit seen;
        rst = 1'b0; startE = 1'b0; signedE = 1'b0; aE = '0; bE = '0; flushE = 1'b0;
        #1;
        chk("reset_valid", 64'(validE), 64'd0);
        chk("reset_busy",  64'(busy),   64'd0);
        chk("reset_lo",    64'(loE),    64'd0);
        chk("reset_hi",    64'(hiE),    64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        do_div("u100_7", 32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2), 33, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_lo", 64'(loE), 64'd14);
        chk("hold_hi", 64'(hiE), 64'd2);

        do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF), 33, 1'b0);
        do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1), 33, 1'b0);
        do_div("div0", 32'h1234, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'h1234), 1, 1'b0);
        do_div("div0_signed", 32'h8000_0005, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'h8000_0005), 1, 1'b0);
        do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0), 33, 1'b0);
        do_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, model(32'hFFFF_FFFF, 32'd1, 1'b0), 33, 1'b0);
        do_div("u_big", 32'hDEAD_BEEF, 32'h0001_2345, 1'b0, model(32'hDEAD_BEEF, 32'h0001_2345, 1'b0), 33, 1'b0);
        do_div("u_small", 32'd5, 32'd9, 1'b0, model(32'd5, 32'd9, 1'b0), 33, 1'b0);
        do_div("u_max_maxm1", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, model(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0), 33, 1'b0);
        do_div("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, model(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1), 33, 1'b0);
        do_div("u_neg_as_unsigned", 32'hFFFF_FFF9, 32'd2, 1'b0, model(32'hFFFF_FFF9, 32'd2, 1'b0), 33, 1'b0);

        // Flush in BUSY: cancel at cycle 10, restart at cycle 12.
        aE = 32'd1000; bE = 32'd3; signedE = 1'b0; startE = 1'b1;
        repeat (10) @(posedge clk);
        #1 flushE = 1'b1;
        #1;
        chk("flush_busy_stall", 64'(stallE), 64'd0);
        chk("flush_busy_valid", 64'(validE), 64'd0);
        chk("flush_busy_still_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flushE = 1'b0; startE = 1'b0;
        #1;
        chk("flush_to_idle", 64'(busy), 64'd0);
        chk("flush_no_valid", 64'(validE), 64'd0);
        @(posedge clk); #1;
        do_div("flush_restart", 32'd20, 32'd3, 1'b0, mk(32'd6, 32'd2), 33, 1'b0);

        // Flush in IDLE blocks the start.
        aE = 32'd50; bE = 32'd5; startE = 1'b1; flushE = 1'b1;
        #1;
        chk("flush_idle_stall", 64'(stallE), 64'd0);
        @(posedge clk); #1;
        chk("flush_idle_blocks", 64'(busy), 64'd0);
        flushE = 1'b0; startE = 1'b0;
        @(posedge clk); #1;

        // Flush landing on the DONE cycle suppresses the pulse.
        aE = 32'd50; bE = 32'd5; startE = 1'b1;
        repeat (33) @(posedge clk);
        #1 flushE = 1'b1;
        #1;
        chk("flush_done_valid", 64'(validE), 64'd0);
        @(posedge clk); #1;
        flushE = 1'b0; startE = 1'b0;
        #1;
        chk("flush_done_idle", 64'(busy), 64'd0);
        chk("flush_done_no_late_valid", 64'(validE), 64'd0);

        // Back-to-back: startE held across DONE, second op with new operands.
        do_div("b2b_first", 32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2), 33, 1'b1);
        first_valid = last_valid_cyc;
        do_div("b2b_second", 32'd20, 32'd3, 1'b0, mk(32'd6, 32'd2), 33, 1'b0);
        chk("b2b_spacing", 64'(last_valid_cyc - first_valid), 64'd34);

        // Async reset mid-divide.
        aE = 32'd1000; bE = 32'd7; signedE = 1'b0; startE = 1'b1;
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(validE), 64'd0);
        chk("rst_mid_busy",  64'(busy),   64'd0);
        chk("rst_mid_lo",    64'(loE),    64'd0);
        chk("rst_mid_hi",    64'(hiE),    64'd0);
        startE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (validE === 1'b1) seen = 1'b1;
        end
        chk("rst_no_pulse_after", 64'(seen), 64'd0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
